// File: rtl/pio_bus_arbiter_pkg.sv
// Shared types and constants for the PIO bus arbiter: FSM encoding,
// PIO register addresses and default widths.
package pio_arb_pkg;

    localparam int DEF_NREQ = 3;
    localparam int DEF_AW   = 4;
    localparam int DEF_DW   = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_WRITE = 1'b1
    } arb_state_e;

    localparam logic [DEF_AW-1:0] ADDR_D_SLAVE   = 4'd0;
    localparam logic [DEF_AW-1:0] ADDR_DD_SLAVE  = 4'd1;
    localparam logic [DEF_AW-1:0] ADDR_DEF_SLAVE = 4'd2;

endpackage

// File: rtl/pio_bus_arbiter_if.sv
// Requester handshake and Avalon-MM write path bundled as one interface.
// Handshake: a requester holds req_valid/addr/data stable until its req_ack
// pulse; the write completes in any WRITE cycle with avm_waitrequest low.
interface pio_bus_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_data;
    logic [NREQ-1:0]         req_ack;
    logic [AW-1:0]           avm_address;
    logic [DW-1:0]           avm_writedata;
    logic                    avm_write;
    logic                    avm_waitrequest;

    modport master (
        input  req_valid, req_addr, req_data, avm_waitrequest,
        output req_ack, avm_address, avm_writedata, avm_write
    );

    modport slave (
        output req_valid, req_addr, req_data, avm_waitrequest,
        input  req_ack, avm_address, avm_writedata, avm_write
    );
endinterface

// File: rtl/pio_bus_arbiter_picker.sv
// Combinational round-robin picker: first asserted request searching
// upward from last_grant+1, wrapping modulo NREQ.
module pio_rr_picker #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    output logic            found_o,
    output logic [IW-1:0]   idx_o
);
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        cand    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            sum = {1'b0, last_grant_i} + (IW+1)'(off);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[IW-1:0];
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/pio_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM write path between NREQ
// requesters; two-state FSM with registered bus outputs.
module pio_bus_arbiter
    import pio_arb_pkg::*;
#(
    parameter int   NREQ = DEF_NREQ,
    parameter int   AW   = DEF_AW,
    parameter int   DW   = DEF_DW,
    localparam int  IW   = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    pio_bus_arbiter_if.master bus,
    output logic [IW-1:0]    grant_id,
    output logic             busy,
    output logic [0:0]       dbg_state_o
);
    localparam logic [0:0] ST_IDLE  = ARB_IDLE;
    localparam logic [0:0] ST_WRITE = ARB_WRITE;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q,  last_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] data_q,  data_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;

    pio_rr_picker #(.NREQ(NREQ)) u_picker (
        .req_i        (bus.req_valid),
        .last_grant_i (last_q),
        .found_o      (pick_found),
        .idx_o        (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    addr_d  = bus.req_addr[pick_idx];
                    data_d  = bus.req_data[pick_idx];
                    state_d = ST_WRITE;
                end
            end
            default: begin
                if (!bus.avm_waitrequest) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // last_q resets to NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        bus.req_ack = '0;
        if (state_q == ST_WRITE && !bus.avm_waitrequest) begin
            bus.req_ack[grant_q] = 1'b1;
        end
    end

    assign bus.avm_write     = (state_q == ST_WRITE);
    assign bus.avm_address   = addr_q;
    assign bus.avm_writedata = data_q;
    assign busy              = (state_q == ST_WRITE);
    assign grant_id          = grant_q;
    assign dbg_state_o       = state_q;
endmodule
